// File: rtl/connect_four_vga.sv
// connect_four_vga: 640x480@60 VGA renderer for a 7x6 Connect Four board.
// Pixel tick every CLK_DIV clocks; two-stage pixel pipeline (decode, colour);
// sync delayed to match. Inputs are snapshotted once per frame at (0,480).
// Optional feature: define CURSOR_BLINK_EN to blink the cursor every 32 frames.
module connect_four_vga #(
    parameter int CLK_DIV = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [41:0] board,
    input  logic [41:0] colors,
    input  logic [2:0]  selected_col,
    input  logic        player,
    input  logic        game_over,
    input  logic [1:0]  winner,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] H_SYNC_S = 10'd656;
    localparam logic [9:0] H_SYNC_E = 10'd751;
    localparam logic [9:0] V_SYNC_S = 10'd490;
    localparam logic [9:0] V_SYNC_E = 10'd491;

    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_RED    = 12'hF00;
    localparam logic [11:0] C_YELLOW = 12'hFF0;
    localparam logic [11:0] C_BLUE   = 12'h00F;
    localparam logic [11:0] C_WHITE  = 12'hFFF;

    // ---------------- pixel tick ----------------
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    // Free-running divider producing one tick every CLK_DIV clocks
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)    r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    // ---------------- raster counters ----------------
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       w_snap_tick;

    // hcount 0..799, vcount 0..524 stepping on hcount wrap
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_tick) begin
            if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                r_vcount <= (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    // Start of vertical blanking: the only place game state is sampled
    assign w_snap_tick = w_tick && (r_hcount == 10'd0) && (r_vcount == V_ACTIVE);

    // ---------------- frame snapshot ----------------
    logic [41:0] r_sn_board;
    logic [41:0] r_sn_colors;
    logic [2:0]  r_sn_sel;
    logic        r_sn_player;
    logic        r_sn_over;
    logic [1:0]  r_sn_winner;

    // Latch game state once per frame so a frame never mixes two states
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sn_board  <= '0;
            r_sn_colors <= '0;
            r_sn_sel    <= '0;
            r_sn_player <= 1'b0;
            r_sn_over   <= 1'b0;
            r_sn_winner <= '0;
        end else if (w_snap_tick) begin
            r_sn_board  <= board;
            r_sn_colors <= colors;
            r_sn_sel    <= selected_col;
            r_sn_player <= player;
            r_sn_over   <= game_over;
            r_sn_winner <= winner;
        end
    end

    logic w_cur_vis;

`ifdef CURSOR_BLINK_EN
    logic [5:0] r_frame;

    // Frame counter; top bit gates the cursor (32 frames on, 32 off)
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)         r_frame <= '0;
        else if (w_snap_tick) r_frame <= r_frame + 6'd1;
    end

    assign w_cur_vis = ~r_frame[5];
`else
    assign w_cur_vis = 1'b1;
`endif

    // ---------------- stage 1: cell / offset decode ----------------
    logic [9:0] w_bx;
    logic [9:0] w_by;
    logic [9:0] w_cy;
    logic       w_in_x;
    logic       w_in_y;
    logic       w_in_cy;
    logic [5:0] w_dy;

    // Offsets wrap when below the region start, so one unsigned compare
    // covers both bounds.
    assign w_bx    = r_hcount - 10'd96;
    assign w_by    = r_vcount - 10'd80;
    assign w_cy    = r_vcount - 10'd16;
    assign w_in_x  = (w_bx < 10'd448);
    assign w_in_y  = (w_by < 10'd384);
    assign w_in_cy = (w_cy < 10'd48);
    // Cursor band is 48 lines tall; shift by 8 to centre the disc in it
    assign w_dy    = w_in_cy ? (w_cy[5:0] + 6'd8) : w_by[5:0];

    logic       r_s1_active;
    logic       r_s1_board;
    logic       r_s1_cursor;
    logic       r_s1_banner;
    logic [2:0] r_s1_col;
    logic [2:0] r_s1_row;
    logic [5:0] r_s1_dx;
    logic [5:0] r_s1_dy;

    // Register the decoded cell position and in-cell offsets
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_active <= 1'b0;
            r_s1_board  <= 1'b0;
            r_s1_cursor <= 1'b0;
            r_s1_banner <= 1'b0;
            r_s1_col    <= '0;
            r_s1_row    <= '0;
            r_s1_dx     <= '0;
            r_s1_dy     <= '0;
        end else if (w_tick) begin
            r_s1_active <= (r_hcount < H_ACTIVE) && (r_vcount < V_ACTIVE);
            r_s1_board  <= w_in_x && w_in_y;
            r_s1_cursor <= w_in_x && w_in_cy;
            r_s1_banner <= (r_vcount < 10'd16);
            r_s1_col    <= w_bx[8:6];
            r_s1_row    <= 3'd5 - w_by[8:6];
            r_s1_dx     <= w_bx[5:0];
            r_s1_dy     <= w_dy;
        end
    end

    // ---------------- stage 2: colour select ----------------
    logic [5:0]  w_adx;
    logic [5:0]  w_ady;
    logic [11:0] w_dist;
    logic        w_hit;
    logic [5:0]  w_idx;
    logic        w_cursor_on;
    logic [11:0] w_banner_c;
    logic [11:0] w_pix;

    assign w_adx  = r_s1_dx[5] ? {1'b0, r_s1_dx[4:0]} : (6'd32 - r_s1_dx);
    assign w_ady  = r_s1_dy[5] ? {1'b0, r_s1_dy[4:0]} : (6'd32 - r_s1_dy);
    assign w_dist = ({6'd0, w_adx} * {6'd0, w_adx}) + ({6'd0, w_ady} * {6'd0, w_ady});
    assign w_hit  = (w_dist < 12'd784);
    assign w_idx  = ({3'd0, r_s1_row} * 6'd7) + {3'd0, r_s1_col};

    assign w_cursor_on = r_s1_cursor && !r_sn_over && w_cur_vis &&
                         (r_sn_sel <= 3'd6) && (r_s1_col == r_sn_sel) && w_hit;

    // Winner code 11 is not a legal result; show it like a draw
    always_comb begin
        w_banner_c = C_WHITE;
        case (r_sn_winner)
            2'b01:   w_banner_c = C_RED;
            2'b10:   w_banner_c = C_YELLOW;
            default: w_banner_c = C_WHITE;
        endcase
    end

    // Priority: blanking, banner, cursor, board disc/frame, background
    always_comb begin
        w_pix = C_BLACK;
        if (!r_s1_active) begin
            w_pix = C_BLACK;
        end else if (r_s1_banner && r_sn_over) begin
            w_pix = w_banner_c;
        end else if (w_cursor_on) begin
            w_pix = r_sn_player ? C_YELLOW : C_RED;
        end else if (r_s1_board) begin
            if (!w_hit)                 w_pix = C_BLUE;
            else if (!r_sn_board[w_idx]) w_pix = C_BLACK;
            else if (r_sn_colors[w_idx]) w_pix = C_YELLOW;
            else                        w_pix = C_RED;
        end
    end

    // ---------------- output registers ----------------
    logic [11:0] r_rgb;
    logic [1:0]  r_hs_pipe;
    logic [1:0]  r_vs_pipe;
    logic        w_hs_raw;
    logic        w_vs_raw;

    assign w_hs_raw = !((r_hcount >= H_SYNC_S) && (r_hcount <= H_SYNC_E));
    assign w_vs_raw = !((r_vcount >= V_SYNC_S) && (r_vcount <= V_SYNC_E));

    // Sync runs through the same two tick stages as the pixel data
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb     <= C_BLACK;
            r_hs_pipe <= 2'b11;
            r_vs_pipe <= 2'b11;
        end else if (w_tick) begin
            r_rgb     <= w_pix;
            r_hs_pipe <= {r_hs_pipe[0], w_hs_raw};
            r_vs_pipe <= {r_vs_pipe[0], w_vs_raw};
        end
    end

    assign hsync = r_hs_pipe[1];
    assign vsync = r_vs_pipe[1];
    assign vga_r = r_rgb[11:8];
    assign vga_g = r_rgb[7:4];
    assign vga_b = r_rgb[3:0];

endmodule

// File: tb/tb_connect_four_vga.sv
// Directed bench for connect_four_vga. Raster position is jumped by forcing
// the counters so that single pixels deep in the frame can be sampled quickly.
module tb_connect_four_vga;

    localparam int DIV = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic [41:0] board = '0;
    logic [41:0] colors = '0;
    logic [2:0]  selected_col = '0;
    logic        player = 1'b0;
    logic        game_over = 1'b0;
    logic [1:0]  winner = '0;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic [11:0] rgb;

    int errors = 0;
    int checks = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    always #5 Clk = ~Clk;

    connect_four_vga #(.CLK_DIV(DIV)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .board(board), .colors(colors),
        .selected_col(selected_col), .player(player), .game_over(game_over),
        .winner(winner), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    task automatic jump(input int h, input int v);
        @(negedge Clk);
        force dut.r_hcount = 10'(h);
        force dut.r_vcount = 10'(v);
        #1;
        release dut.r_hcount;
        release dut.r_vcount;
    endtask

    // Any 2*DIV consecutive clocks hold exactly two ticks: the output then
    // shows the pixel at the jumped-to position.
    task automatic pix(input int x, input int y, output logic [11:0] p);
        jump(x, y);
        repeat (2 * DIV) @(posedge Clk);
        @(negedge Clk);
        p = rgb;
    endtask

    task automatic load_snap(input logic [41:0] b, input logic [41:0] c, input logic [2:0] s,
                             input logic pl, input logic go, input logic [1:0] w);
        board = b; colors = c; selected_col = s; player = pl; game_over = go; winner = w;
        jump(0, 480);
        repeat (2 * DIV) @(posedge Clk);
    endtask

    task automatic do_reset;
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset;
        #2 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", rgb); end
        Reset_n = 1'b1;
    endtask

    task automatic test_hsync_timing;
        int t = 0, t_fall = -1, t_rise = -1, t_fall2 = -1;
        logic prev;
        prev = hsync;
        for (int i = 0; i < 12000; i++) begin
            @(negedge Clk);
            t++;
            if (prev && !hsync) begin
                if (t_fall < 0) t_fall = t;
                else if (t_fall2 < 0) t_fall2 = t;
            end
            if (!prev && hsync && t_fall >= 0 && t_rise < 0) t_rise = t;
            prev = hsync;
            if (t_fall2 >= 0) break;
        end
        checks++; if (t_rise - t_fall != 384) begin errors++; $display("FAIL hsync_low: got %0d want 384", t_rise - t_fall); end
        checks++; if (t_fall2 - t_fall != 3200) begin errors++; $display("FAIL hsync_period: got %0d want 3200", t_fall2 - t_fall); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL vsync_idle: got %b want 1", vsync); end
    endtask

    task automatic test_vsync_timing;
        int t = 0, t_fall = -1, t_rise = -1;
        logic prev;
        jump(0, 489);
        prev = vsync;
        for (int i = 0; i < 12000; i++) begin
            @(negedge Clk);
            t++;
            if (prev && !vsync && t_fall < 0) t_fall = t;
            if (!prev && vsync && t_fall >= 0) begin t_rise = t; break; end
            prev = vsync;
        end
        checks++; if (t_rise - t_fall != 6400 || t_fall < 0) begin errors++; $display("FAIL vsync_low: got %0d want 6400", t_rise - t_fall); end
    endtask

    task automatic test_first_frame;
        logic [11:0] p;
        pix(128, 40, p);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL first_cursor: got %h want f00", p); end
        pix(128, 432, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL first_empty: got %h want 000", p); end
        pix(320, 40, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL first_nocursor: got %h want 000", p); end
    endtask

    task automatic test_disc;
        logic [11:0] p;
        load_snap(42'h1, 42'h0, 3'd0, 1'b0, 1'b0, 2'b00);
        pix(128, 432, p);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL disc_red: got %h want f00", p); end
        pix(100, 84, p);
        checks++; if (p !== 12'h00F) begin errors++; $display("FAIL board_blue: got %h want 00f", p); end
        pix(128, 368, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL slot_empty: got %h want 000", p); end
    endtask

    // Disc spans dx 5..59 on its centre line; adjacent pixels differ, so a
    // wrong pipeline depth shows up here.
    task automatic test_pipeline_edge;
        logic [11:0] p;
        pix(100, 432, p);
        checks++; if (p !== 12'h00F) begin errors++; $display("FAIL edge_l_out: got %h want 00f", p); end
        pix(101, 432, p);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL edge_l_in: got %h want f00", p); end
        pix(155, 432, p);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL edge_r_in: got %h want f00", p); end
        pix(156, 432, p);
        checks++; if (p !== 12'h00F) begin errors++; $display("FAIL edge_r_out: got %h want 00f", p); end
    endtask

    task automatic test_p1_disc;
        logic [11:0] p;
        load_snap(42'h1 << 41, 42'h1 << 41, 3'd0, 1'b0, 1'b0, 2'b00);
        pix(512, 112, p);
        checks++; if (p !== 12'hFF0) begin errors++; $display("FAIL disc_p1: got %h want ff0", p); end
    endtask

    task automatic test_cursor;
        logic [11:0] p;
        load_snap(42'h0, 42'h0, 3'd6, 1'b1, 1'b0, 2'b00);
        pix(512, 40, p);
        checks++; if (p !== 12'hFF0) begin errors++; $display("FAIL cursor_p1: got %h want ff0", p); end
        pix(320, 40, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL cursor_other_col: got %h want 000", p); end
        pix(512, 16, p);
        checks++; if (p !== 12'hFF0) begin errors++; $display("FAIL cursor_top: got %h want ff0", p); end
        pix(512, 15, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL cursor_above: got %h want 000", p); end
        load_snap(42'h0, 42'h0, 3'd3, 1'b0, 1'b0, 2'b00);
        pix(320, 40, p);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL cursor_red: got %h want f00", p); end
    endtask

    task automatic test_banner;
        logic [11:0] p;
        load_snap(42'h0, 42'h0, 3'd6, 1'b1, 1'b1, 2'b00);
        pix(5, 5, p);
        checks++; if (p !== 12'hFFF) begin errors++; $display("FAIL banner_draw: got %h want fff", p); end
        pix(512, 40, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL banner_nocursor: got %h want 000", p); end
        pix(639, 15, p);
        checks++; if (p !== 12'hFFF) begin errors++; $display("FAIL banner_corner: got %h want fff", p); end
        pix(5, 16, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL banner_below: got %h want 000", p); end
        load_snap(42'h0, 42'h0, 3'd6, 1'b1, 1'b1, 2'b01);
        pix(5, 5, p);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL banner_red: got %h want f00", p); end
        load_snap(42'h0, 42'h0, 3'd6, 1'b1, 1'b1, 2'b10);
        pix(5, 5, p);
        checks++; if (p !== 12'hFF0) begin errors++; $display("FAIL banner_p1: got %h want ff0", p); end
        load_snap(42'h0, 42'h0, 3'd6, 1'b1, 1'b1, 2'b11);
        pix(5, 5, p);
        checks++; if (p !== 12'hFFF) begin errors++; $display("FAIL banner_w11: got %h want fff", p); end
    endtask

    task automatic test_sel_oob;
        logic [11:0] p;
        load_snap(42'h0, 42'h0, 3'd7, 1'b1, 1'b0, 2'b00);
        pix(512, 40, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL sel7_nocursor: got %h want 000", p); end
    endtask

    task automatic test_bounds;
        logic [11:0] p;
        load_snap({42{1'b1}}, 42'h0, 3'd0, 1'b0, 1'b0, 2'b00);
        pix(543, 463, p);
        checks++; if (p !== 12'h00F) begin errors++; $display("FAIL board_corner: got %h want 00f", p); end
        pix(544, 100, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL right_of_board: got %h want 000", p); end
        pix(640, 100, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL h_blank: got %h want 000", p); end
        pix(200, 480, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL v_blank: got %h want 000", p); end
    endtask

    task automatic test_midframe;
        logic [11:0] p;
        load_snap(42'h1, 42'h0, 3'd0, 1'b0, 1'b0, 2'b00);
        jump(0, 200);
        repeat (DIV) @(posedge Clk);
        board = 42'h0;
        pix(128, 432, p);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL midframe_hold: got %h want f00", p); end
        load_snap(42'h0, 42'h0, 3'd0, 1'b0, 1'b0, 2'b00);
        pix(128, 432, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL midframe_next: got %h want 000", p); end
    endtask

    task automatic test_reset_midframe;
        logic [11:0] p;
        load_snap(42'h1, 42'h0, 3'd6, 1'b1, 1'b0, 2'b00);
        pix(700, 100, p);
        checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL pre_reset_hsync: got %b want 0", hsync); end
        Reset_n = 1'b0;
        #1;
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL async_hsync: got %b want 1", hsync); end
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL async_rgb: got %h want 000", rgb); end
        @(negedge Clk);
        Reset_n = 1'b1;
        pix(128, 432, p);
        checks++; if (p !== 12'h000) begin errors++; $display("FAIL snap_cleared: got %h want 000", p); end
        pix(128, 40, p);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL cursor_cleared: got %h want f00", p); end
    endtask

    task automatic test_blink;
        logic [11:0] p;
        logic [11:0] exp_hidden;
`ifdef CURSOR_BLINK_EN
        exp_hidden = 12'h000;
`else
        exp_hidden = 12'hF00;
`endif
        do_reset();
        load_snap(42'h0, 42'h0, 3'd0, 1'b0, 1'b0, 2'b00);
        pix(128, 40, p);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL blink_frame1: got %h want f00", p); end
        repeat (31) load_snap(42'h0, 42'h0, 3'd0, 1'b0, 1'b0, 2'b00);
        pix(128, 40, p);
        checks++; if (p !== exp_hidden) begin errors++; $display("FAIL blink_frame32: got %h want %h", p, exp_hidden); end
        repeat (32) load_snap(42'h0, 42'h0, 3'd0, 1'b0, 1'b0, 2'b00);
        pix(128, 40, p);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL blink_frame64: got %h want f00", p); end
    endtask

    initial begin
        test_reset();
        test_hsync_timing();
        test_first_frame();
        test_vsync_timing();
        test_disc();
        test_pipeline_edge();
        test_p1_disc();
        test_cursor();
        test_banner();
        test_sel_oob();
        test_bounds();
        test_midframe();
        test_reset_midframe();
        test_blink();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
